cache_xfer_arbiter: RTL and testbench
=====================================

# cache_xfer_arbiter

Shares the single backing-memory row-transfer channel between the per-bank `cache` controllers. Each cache raises `hold` while in WriteBack or Allocate. The arbiter grants one requester at a time, round-robin, and streams the row transfer as `BEATS` beats to backing memory. It then returns the one-cycle `sync` pulse that moves that cache out of its wait state. It sits between the bank caches and the backing-memory model.

## Interface
Parameters:
- `NREQ`, 4: number of requesting caches (≥2).
- `ROWW`, 17: row-id width (matches `RowId`).
- `BEATS`, 8: beats per row transfer (≥2, power of two).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `hold`  in  NREQ  per-cache transfer request, level; driven by each cache's `hold`.
- `wb`  in  NREQ  per-cache direction: 1 = WriteBack (cache→mem), 0 = Allocate (mem→cache).
- `row`  in  NREQ*ROWW  flattened row ids; requester i occupies `[i*ROWW +: ROWW]`.
- `gnt`  out  NREQ  one-hot grant, held for the whole transfer.
- `sync`  out  NREQ  one-cycle completion pulse to the granted requester.
- `busy`  out  1  transfer in progress (XFER or DONE).
- `mem_valid`  out  1  beat valid to backing memory.
- `mem_wr`  out  1  1 = write beat (writeback), 0 = read beat (allocate).
- `mem_row`  out  ROWW  row id of the current transfer.
- `mem_beat`  out  $clog2(BEATS)  beat index, 0..BEATS-1.
- `mem_ready`  in  1  backing memory accepts beat this cycle.

## Operation
- State machine:
  - IDLE → XFER when `|hold`.
  - XFER: stays while beats remain; → DONE when `mem_valid && mem_ready && mem_beat == BEATS-1`.
  - DONE → IDLE, unconditionally.
- IDLE arbitration: round-robin pick from `hold`.
  - Search starts at pointer `ptr`, increasing index, wrapping at NREQ.
  - `ptr` resets to 0. On each grant to i, `ptr` ← (i+1) mod NREQ.
- On the IDLE→XFER edge, register into flops:
  - `gnt` ← onehot(i)
  - `mem_row` ← row slice i
  - `mem_wr` ← `wb[i]`
  - `mem_beat` ← 0
- Captured values stay stable through XFER and DONE. Later changes on `row`/`wb` are ignored.
- XFER:
  - `mem_valid`=1.
  - `mem_beat` increments by 1 on each cycle with `mem_ready`=1.
  - `mem_ready`=0 stalls with all outputs held.
- DONE:
  - `mem_valid`=0, `sync[i]`=1 for exactly one cycle.
  - `gnt` stays one-hot during DONE and clears on the DONE→IDLE edge.
- `sync` is never asserted outside DONE. At most one bit of `gnt` or `sync` is set.
- `busy` = state is XFER or DONE.
- Requester drops `hold` mid-transfer (protocol violation): the transfer still completes and `sync` still pulses.
- WriteBack→Allocate chain: the cache keeps `hold` high after `sync`. In the following IDLE cycle it competes as a fresh request. The round-robin pointer has already advanced past it, so waiting requesters are served first.
- Reset (any time, including mid-XFER): state IDLE, `ptr`=0, transfer abandoned, no `sync` emitted.
- Reset value of every output: 0 (`gnt`, `sync`, `busy`, `mem_valid`, `mem_wr`, `mem_row`, `mem_beat`).

## Timing
- `hold` high in IDLE cycle t → `gnt`, `mem_valid`, `busy` high from t+1.
- With `mem_ready` held at 1:
  - beats 0..BEATS-1 in cycles t+1..t+BEATS.
  - `sync` in cycle t+BEATS+1.
  - IDLE in t+BEATS+2.
- Each `mem_ready`=0 cycle in XFER adds one cycle.
- Back-to-back transfer period: BEATS+2 cycles. One IDLE cycle is mandatory between grants, which lets the cache's registered `hold` settle after `sync`.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `memulator_pkg`:
  - `xfer_state_t` enum: IDLE=2'b00, XFER=2'b01, DONE=2'b10.
  - default `ROWW` constant.
- Sub-module `rr_arbiter`, parameter NREQ, purely combinational:
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `pick`, index `pick_idx`, `any`.
- Top level holds the FSM, `ptr`, the beat counter and the capture registers.

## Test plan
NREQ=4, BEATS=4, ROWW=17.
- Single allocate: `hold`=4'b0100, `wb[2]`=0, row2=17'h1ABCD, `mem_ready`=1 →
  - `gnt`=4'b0100, `mem_wr`=0, `mem_row`=17'h1ABCD.
  - `mem_beat` 0,1,2,3 on consecutive cycles.
  - `sync`=4'b0100 exactly 5 cycles after `hold`.
- Round-robin: `hold`=4'b1111 held, `mem_ready`=1 → grant order 0,1,2,3,0. Successive `sync` pulses are 6 cycles apart.
- Stall: during a transfer, `mem_ready`=0 for 3 cycles at beat 2 → `mem_beat` holds at 2, outputs stable. `sync` is delayed by exactly 3 cycles.
- WriteBack→Allocate chain: cache 1 with `wb`=1, then `hold` kept high with `wb`=0 after `sync`; cache 3 requesting meanwhile → order is 1 (wr), 3, 1 (rd).
- Reset mid-XFER at beat 1 → all outputs 0 immediately. No `sync` follows. After release, `hold`=4'b0010 → grant 1 (`ptr`=0 search).
- Protocol check: requester drops `hold` at beat 1 → all 4 beats still issued and the `sync` pulse still occurs. Assertions: `gnt` and `sync` are one-hot-or-zero, and `sync` is only set in DONE.

Source files
------------

// File: rtl/memulator_pkg.sv
// rtl/memulator_pkg.sv - shared types and constants for the backing-memory transfer path
package memulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } xfer_state_t;

  localparam int ROWW_DEFAULT = 17;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_xfer_arbiter_if.sv
// rtl/cache_xfer_arbiter_if.sv - bank-cache request side and backing-memory beat side of the arbiter
interface cache_xfer_arbiter_if import memulator_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int ROWW  = ROWW_DEFAULT,
  parameter int BEATS = 8
);

  localparam int BW = $clog2(BEATS);

  logic [NREQ-1:0]      hold;
  logic [NREQ-1:0]      wb;
  logic [NREQ*ROWW-1:0] row;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      sync;
  logic                 busy;
  logic                 mem_valid;
  logic                 mem_wr;
  logic [ROWW-1:0]      mem_row;
  logic [BW-1:0]        mem_beat;
  logic                 mem_ready;

  modport master (
    output hold, wb, row, mem_ready,
    input  gnt, sync, busy, mem_valid, mem_wr, mem_row, mem_beat
  );

  modport slave (
    input  hold, wb, row, mem_ready,
    output gnt, sync, busy, mem_valid, mem_wr, mem_row, mem_beat
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter import memulator_pkg::*; #(
  parameter int NREQ = 4,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx,
  output logic            any
);

  int idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_xfer_arbiter.sv
// rtl/cache_xfer_arbiter.sv - grants the row-transfer channel round-robin and streams BEATS beats per grant
module cache_xfer_arbiter import memulator_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int ROWW  = ROWW_DEFAULT,
  parameter int BEATS = 8
) (
  input logic            clk,
  input logic            rst,
  cache_xfer_arbiter_if.slave bus
);

  localparam int PW = idx_w(NREQ);
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  xfer_state_t     state, state_n;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic            any;
  logic [NREQ-1:0] gnt_q;
  logic [ROWW-1:0] row_q;
  logic            wr_q;
  logic [BW-1:0]   beat_q;
  logic [NREQ-1:0] sync_c;
  logic            busy_c;
  logic            valid_c;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req      (bus.hold),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Everything below decodes registered state only, so outputs never see inputs combinationally.
  always_comb begin
    state_n = state;
    sync_c  = '0;
    busy_c  = 1'b0;
    valid_c = 1'b0;
    case (state)
      IDLE: if (any) state_n = XFER;
      XFER: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        if (bus.mem_ready && beat_q == LAST) state_n = DONE;
      end
      DONE: begin
        busy_c  = 1'b1;
        sync_c  = gnt_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant-time capture; the requester's row/wb are ignored for the rest of the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      gnt_q  <= '0;
      row_q  <= '0;
      wr_q   <= 1'b0;
      beat_q <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          gnt_q  <= pick;
          row_q  <= bus.row[int'(pick_idx)*ROWW +: ROWW];
          wr_q   <= bus.wb[pick_idx];
          beat_q <= '0;
          ptr    <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        XFER: if (bus.mem_ready && beat_q != LAST) beat_q <= beat_q + 1'b1;
        DONE: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sync      = sync_c;
  assign bus.busy      = busy_c;
  assign bus.mem_valid = valid_c;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_row   = row_q;
  assign bus.mem_beat  = beat_q;

endmodule

// File: tb/tb_cache_xfer_arbiter.sv
// tb/tb_cache_xfer_arbiter.sv - directed vector and sequence bench for cache_xfer_arbiter
module tb_cache_xfer_arbiter;

  localparam int NREQ  = 4;
  localparam int ROWW  = 17;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_xfer_arbiter_if #(.NREQ(NREQ), .ROWW(ROWW), .BEATS(BEATS)) bus ();

  cache_xfer_arbiter #(.NREQ(NREQ), .ROWW(ROWW), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  hold;
    logic [3:0]  wb;
    logic        rdy;
    logic [3:0]  gnt;
    logic [3:0]  sync;
    logic        busy;
    logic        valid;
    logic        wr;
    logic [16:0] mrow;
    logic [1:0]  beat;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return 32'(|{bus.gnt, bus.sync, bus.busy, bus.mem_valid, bus.mem_wr, bus.mem_row, bus.mem_beat});
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.hold      = '0;
    bus.wb        = '0;
    bus.mem_ready = 1'b1;
    tick();
    chk("reset_outputs_zero", all_out(), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.hold = '0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.busy) break;
      tick();
    end
    chk("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("sync_onehot0", 32'($onehot0(bus.sync)), 32'd1);
      chk("sync_only_in_done", 32'((bus.sync == '0) || (bus.busy && !bus.mem_valid && bus.sync == bus.gnt)), 32'd1);
    end
  end

  initial begin
    int n;
    int t0;
    int found;
    int cnt;
    int order[5];
    int tsync[5];
    int widx[3];
    int wwr[3];
    int n1;

    bus.hold      = '0;
    bus.wb        = '0;
    bus.mem_ready = 1'b1;
    bus.row       = {17'h13333, 17'h1ABCD, 17'h00122, 17'h00011};

    //            hold     wb       rdy   gnt      sync     busy  valid wr    row        beat
    vt[0]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 17'h1ABCD, 2'd0};
    vt[1]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 17'h1ABCD, 2'd1};
    vt[2]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 17'h1ABCD, 2'd2};
    vt[3]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 17'h1ABCD, 2'd3};
    vt[4]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 17'h1ABCD, 2'd0};
    vt[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 17'h00000, 2'd0};
    vt[6]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 17'h00011, 2'd0};
    vt[7]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 17'h00011, 2'd0};
    vt[8]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 17'h00011, 2'd1};
    vt[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 17'h00011, 2'd2};
    vt[10] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 17'h00011, 2'd3};
    vt[11] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 17'h00011, 2'd0};
    vt[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 17'h00000, 2'd0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      bus.hold      = vt[i].hold;
      bus.wb        = vt[i].wb;
      bus.mem_ready = vt[i].rdy;
      tick();
      chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d_sync", i), 32'(bus.sync), 32'(vt[i].sync));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_valid", i), 32'(bus.mem_valid), 32'(vt[i].valid));
      if (vt[i].busy) begin
        chk($sformatf("v%0d_wr", i), 32'(bus.mem_wr), 32'(vt[i].wr));
        chk($sformatf("v%0d_row", i), 32'(bus.mem_row), 32'(vt[i].mrow));
      end
      if (vt[i].valid) chk($sformatf("v%0d_beat", i), 32'(bus.mem_beat), 32'(vt[i].beat));
    end

    // Round-robin with all four requesting.
    do_reset();
    bus.hold = 4'b1111;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      tick();
      if (bus.sync != '0) begin
        order[n] = $clog2(bus.sync);
        tsync[n] = cyc;
        n++;
      end
    end
    bus.hold = '0;
    chk("rr_sync_count", 32'(n), 32'd5);
    for (int i = 0; i < n; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
    for (int i = 1; i < n; i++) chk($sformatf("rr_period%0d", i), 32'(tsync[i] - tsync[i-1]), 32'd6);
    drain();

    // Three stall cycles at beat 2.
    do_reset();
    bus.hold = 4'b0001;
    t0 = cyc;
    tick();
    tick();
    tick();
    chk("stall_pre_beat", 32'(bus.mem_beat), 32'd2);
    bus.mem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall%0d_beat", s), 32'(bus.mem_beat), 32'd2);
      chk($sformatf("stall%0d_valid_gnt", s), 32'({bus.mem_valid, bus.gnt}), 32'(5'b1_0001));
    end
    bus.mem_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.sync != '0) begin
        found = 1;
        chk("stall_sync_time", 32'(cyc - t0), 32'd8);
        break;
      end
    end
    chk("stall_sync_seen", 32'(found), 32'd1);
    drain();

    // WriteBack then Allocate on cache 1 while cache 3 waits.
    do_reset();
    bus.wb   = 4'b0010;
    bus.hold = 4'b1010;
    n  = 0;
    n1 = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      tick();
      if (bus.sync != '0) begin
        widx[n] = $clog2(bus.sync);
        wwr[n]  = int'(bus.mem_wr);
        n++;
        if (bus.sync[1]) begin
          if (n1 == 0) bus.wb[1] = 1'b0;
          else         bus.hold[1] = 1'b0;
          n1++;
        end
        if (bus.sync[3]) bus.hold[3] = 1'b0;
      end
    end
    chk("chain_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("chain_idx0", 32'(widx[0]), 32'd1);
      chk("chain_wr0", 32'(wwr[0]), 32'd1);
      chk("chain_idx1", 32'(widx[1]), 32'd3);
      chk("chain_idx2", 32'(widx[2]), 32'd1);
      chk("chain_wr2", 32'(wwr[2]), 32'd0);
    end
    drain();

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    bus.hold = 4'b0100;
    tick();
    tick();
    chk("rst_mid_beat1", 32'(bus.mem_beat), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs_zero", all_out(), 32'd0);
    bus.hold = '0;
    tick();
    rst   = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.sync != '0 || bus.busy) found = 1;
    end
    chk("rst_no_sync_after", 32'(found), 32'd0);
    bus.hold = 4'b0010;
    tick();
    chk("rst_then_gnt1", 32'(bus.gnt), 32'(4'b0010));
    drain();

    // Requester drops hold mid-transfer.
    do_reset();
    bus.hold = 4'b0001;
    tick();
    tick();
    chk("drop_beat1", 32'(bus.mem_beat), 32'd1);
    bus.hold = '0;
    cnt   = 2;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_valid) begin
        chk($sformatf("drop_beat_idx%0d", cnt), 32'(bus.mem_beat), 32'(cnt));
        cnt++;
      end
      if (bus.sync == 4'b0001) begin
        found = 1;
        break;
      end
    end
    chk("drop_beats_total", 32'(cnt), 32'd4);
    chk("drop_sync_seen", 32'(found), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
